// File: rtl/sbit_pkg.sv
// Shared width, word type and golden-sum helper for the sbit_add16 adder.
package sbit_pkg;

  localparam int SBIT_WIDTH = 16;

  typedef logic [SBIT_WIDTH-1:0] sbit_word_t;

  function automatic logic [SBIT_WIDTH:0] add_ref(input sbit_word_t a,
                                                  input sbit_word_t b,
                                                  input logic       cin);
    add_ref = {1'b0, a} + {1'b0, b} + {{SBIT_WIDTH{1'b0}}, cin};
  endfunction

endpackage

// File: rtl/sbit_fa.sv
// One-bit full adder cell; the ripple chain in sbit_add16 is built from these.
module sbit_fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic sum,
  output logic co
);

  logic p;

  assign p   = x ^ y;
  assign sum = p ^ ci;
  assign co  = (x & y) | (ci & p);

endmodule

// File: rtl/sbit_add16.sv
// Registered ripple-carry adder: {c,s} = a + b + cin, one clock of latency.
// Optional registered two's-complement overflow output when SBIT_OVF_EN is defined.
module sbit_add16
  import sbit_pkg::*;
#(
  parameter int WIDTH = SBIT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
`ifdef SBIT_OVF_EN
  output logic             ovf,
`endif
  output logic             c
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    sbit_fa u_fa (
      .x   (a[i]),
      .y   (b[i]),
      .ci  (carry[i]),
      .sum (sum[i]),
      .co  (carry[i+1])
    );
  end

  // ---- register stage ----
  logic [WIDTH-1:0] s_d, s_q;
  logic             c_d, c_q;

  always_comb begin
    s_d = sum;
    c_d = carry[WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q <= '0;
      c_q <= 1'b0;
    end else begin
      s_q <= s_d;
      c_q <= c_d;
    end
  end

  assign s = s_q;
  assign c = c_q;

`ifdef SBIT_OVF_EN
  logic ovf_d, ovf_q;

  // Signed overflow: carry into the sign bit differs from carry out of it.
  always_comb begin
    ovf_d = carry[WIDTH] ^ carry[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_sbit_add16.sv
// Bench for sbit_add16: directed steps then randomized cycles with reset pulses.
// Define SBIT_OVF_EN to also exercise the ovf output.
module tb_sbit_add16;

  logic        clk;
  logic        rst_n;
  logic [15:0] a, b;
  logic        cin;
  logic [15:0] s;
  logic        c;
`ifdef SBIT_OVF_EN
  logic        ovf;
`endif

  int total = 0;
  int bad   = 0;

  sbit_add16 #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .s     (s),
`ifdef SBIT_OVF_EN
    .ovf   (ovf),
`endif
    .c     (c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Apply inputs, clock one edge, then check the registered result against
  // plain integer arithmetic on the applied operands.
  task automatic step(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                      input logic tcin, input logic trst_n);
    int unsigned full;
    logic [15:0] es;
    logic        ec, eo;
    a     = ta;
    b     = tb_v;
    cin   = tcin;
    rst_n = trst_n;
    full  = int'(ta) + int'(tb_v) + int'(tcin);
    es    = full[15:0];
    ec    = (full > 32'hFFFF);
    // Signed overflow: both operands share a sign that the result lacks.
    eo    = (ta[15] == tb_v[15]) && (es[15] != ta[15]);
    if (!trst_n) begin
      es = '0;
      ec = 1'b0;
      eo = 1'b0;
    end
    @(posedge clk);
    #1;
    check({tag, ".s"}, {1'b0, s}, {1'b0, es});
    check({tag, ".c"}, {16'h0, c}, {16'h0, ec});
`ifdef SBIT_OVF_EN
    check({tag, ".ovf"}, {16'h0, ovf}, {16'h0, eo});
`else
    if (eo) ;
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    @(negedge clk);

    step("rst0", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    step("rst1", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    step("rel",  16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
    step("dec",  16'd123,  16'd224,  1'b0, 1'b1);
    step("wrap", 16'hFFFF, 16'h0000, 1'b1, 1'b1);
    step("mix0", 16'hF050, 16'h0A95, 1'b0, 1'b1);
    step("mix1", 16'hF050, 16'hF1E1, 1'b0, 1'b1);
    step("mix2", 16'hF050, 16'hDC1A, 1'b0, 1'b1);
    step("ovfp", 16'h7FFF, 16'h0001, 1'b0, 1'b1);
    step("ovfn", 16'h8000, 16'h8000, 1'b0, 1'b1);
    step("zero", 16'h0000, 16'h0000, 1'b0, 1'b1);
    step("midr", 16'h1234, 16'h4321, 1'b1, 1'b0);
    step("post", 16'h1234, 16'h4321, 1'b1, 1'b1);

    for (int i = 0; i < 10000; i++) begin
      step("rnd", 16'($urandom), 16'($urandom), 1'($urandom),
           ($urandom_range(0, 31) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
